// File: rtl/mul_add_pkg.sv
// Shared definitions for the multiply-add rebuild unit.
//   state_t       : control states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : width of the step counter, ceil(log2(width)) but at least 1
package mul_add_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mul_add_rebuild.sv
// Sequential multiply-add: rebuilds a dividend OUT = Q*D + R from divider
// outputs using a WIDTH-step shift-add sequence. ERR flags operand sets a
// correct divider could not produce (D == 0 or R >= D). ERR does not stop
// the arithmetic, and the result is delivered anyway.
//
// Ports:
//   CLK, RST_N   clock and asynchronous active-low reset
//   IN_VALID     operand set present on Q, D, R
//   IN_READY     operands accepted this cycle (IDLE only)
//   Q, D, R      quotient, divisor, remainder (unsigned, WIDTH bits)
//   OUT_VALID    OUT and ERR hold a result (DONE only)
//   OUT_READY    consumer takes the result this cycle
//   OUT          reconstructed dividend, 2*WIDTH bits
//   ERR          result flagged as impossible for a correct divider
//   dbg_state    current control state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. IN_READY and OUT_VALID are decoded from the state register
// alone, so neither depends combinationally on IN_VALID or OUT_READY.
// Because IN_READY is low in DONE, a new operand set can be accepted no
// earlier than the cycle after the result handshake.
module mul_add_rebuild
    import mul_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   Q,
    input  logic [WIDTH-1:0]   D,
    input  logic [WIDTH-1:0]   R,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [2*WIDTH-1:0] OUT,
    output logic               ERR,
    output state_t             dbg_state
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t               state_q;
    state_t               state_d;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 err_q;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        state_d   = state_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The last step still executes on the edge that leaves RUN.
                if (cnt == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, one shift-add step per RUN cycle.
    // The accumulator starts at R so the final value is Q*D + R directly.
    // Max result (2^W-1)^2 + (2^W-1) fits in 2*WIDTH bits, so no carry out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        acc    <= {{WIDTH{1'b0}}, R};
                        mcand  <= {{WIDTH{1'b0}}, D};
                        mplier <= Q;
                        cnt    <= '0;
                        err_q  <= (D == '0) || (R >= D);
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                default: begin
                    // DONE holds acc and err_q stable under backpressure.
                end
            endcase
        end
    end

    assign OUT       = acc;
    assign ERR       = err_q;
    assign dbg_state = state_q;

endmodule
